// File: rtl/background_fill_ctrl.sv
// background_fill_ctrl: rectangle fill write sequencer for the 320x240
// column-major background frame RAM (addr = y + 240*x). Accepts one command
// at a time, clips it to the screen, and issues one RAM write per clock.
module background_fill_ctrl #(
  parameter int NUMBER_COLORS = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [8:0]                       cmd_x0,
  input  logic [8:0]                       cmd_x1,
  input  logic [7:0]                       cmd_y0,
  input  logic [7:0]                       cmd_y1,
  input  logic [$clog2(NUMBER_COLORS):0]   cmd_color,
  input  logic                             abort,
  output logic [16:0]                      ram_waddr,
  output logic [$clog2(NUMBER_COLORS):0]   ram_din,
  output logic                             ram_we,
  output logic                             busy,
  output logic                             done
);

  localparam int CW = $clog2(NUMBER_COLORS) + 1;

  localparam logic [8:0] X_MAX = 9'd319;
  localparam logic [7:0] Y_MAX = 8'd239;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_FILL,
    S_DONE
  } state_t;

  state_t        state_q, state_d;

  // Latched command fields; x1/y1 are overwritten with their clipped values in SETUP.
  logic [8:0]    x0_q, x0_d;
  logic [8:0]    x1_q, x1_d;
  logic [7:0]    y0_q, y0_d;
  logic [7:0]    y1_q, y1_d;
  logic [CW-1:0] color_q, color_d;

  // Fill walk: current pixel, its RAM address, and the column-to-column jump.
  logic [8:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic [16:0]   addr_q, addr_d;
  logic [7:0]    stride_q, stride_d;

  // Setup-stage combinational helpers.
  logic [8:0]    x1_clip;
  logic [7:0]    y1_clip;
  logic          empty_cmd;
  logic [16:0]   x0_ext;
  logic [16:0]   start_addr;
  logic [7:0]    col_stride;

  // Clip, emptiness test and start address derived from the latched command.
  always_comb begin
    x1_clip    = (x1_q > X_MAX) ? X_MAX : x1_q;
    y1_clip    = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    empty_cmd  = (x0_q > X_MAX) || (y0_q > Y_MAX) ||
                 (x0_q > x1_clip) || (y0_q > y1_clip);
    x0_ext     = {8'd0, x0_q};
    // 240*x0 as (x0<<8)-(x0<<4); with x0 <= 319 the result stays below 76800.
    start_addr = (x0_ext << 8) - (x0_ext << 4) + {9'd0, y0_q};
    // Jump from (x,y1c) to (x+1,y0): 240 - (y1c - y0).
    col_stride = 8'd240 - (y1_clip - y0_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      color_q  <= color_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    color_d  = color_q;
    x_d      = x_q;
    y_d      = y_q;
    addr_d   = addr_q;
    stride_d = stride_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          x1_d    = cmd_x1;
          y0_d    = cmd_y0;
          y1_d    = cmd_y1;
          color_d = cmd_color;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (abort || empty_cmd) begin
          state_d = S_DONE;
        end else begin
          x1_d     = x1_clip;
          y1_d     = y1_clip;
          x_d      = x0_q;
          y_d      = y0_q;
          addr_d   = start_addr;
          stride_d = col_stride;
          state_d  = S_FILL;
        end
      end

      S_FILL: begin
        // The write at addr_q is presented this cycle regardless of abort.
        if (abort || ((x_q == x1_q) && (y_q == y1_q))) begin
          state_d = S_DONE;
        end else if (y_q == y1_q) begin
          x_d    = x_q + 9'd1;
          y_d    = y0_q;
          addr_d = addr_q + {9'd0, stride_q};
        end else begin
          y_d    = y_q + 8'd1;
          addr_d = addr_q + 17'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register so reset clears ram_we at once.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    ram_we    = (state_q == S_FILL);
    done      = (state_q == S_DONE);
    ram_waddr = addr_q;
    ram_din   = color_q;
  end

endmodule
